multibit_set_reset_queue: RTL

- Queued successor to the single-shot multibit set/reset latch.
- Software/pulse-sequencer writes masked update words (mode, mask, value, payload) into a DEPTH-entry FIFO.
- Each `apply` strobe pops the oldest entry and applies it to the persistent output word `q` in one of four modes, latching the accompanying payload.
- Sits between the pulse-program command decoder and the DDS/shutter output registers, so several updates can be staged ahead of a timed trigger.

---
 rtl/multibit_set_reset_queue_if.sv | 36 +++
 rtl/multibit_set_reset_queue.sv | 139 +++++++++++++
 2 files changed

// File: rtl/multibit_set_reset_queue_if.sv
// Bus bundle for the queued multibit set/reset block: push-side command
// fields, apply/clear strobes, and the registered status/output word.
interface multibit_set_reset_queue_if #(
    parameter int BITS   = 38,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BITS-1:0]   set_data;
    logic [BITS-1:0]   set_mask;
    logic [1:0]        mode;
    logic [DATA_W-1:0] data;
    logic              push;
    logic              apply;
    logic              clear;

    logic [BITS-1:0]   q;
    logic [DATA_W-1:0] data_buffer;
    logic              applied;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output set_data, set_mask, mode, data, push, apply, clear,
        input  q, data_buffer, applied, count, full, empty, overflow, underflow
    );

    modport slave (
        input  set_data, set_mask, mode, data, push, apply, clear,
        output q, data_buffer, applied, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/multibit_set_reset_queue.sv
// Queued multibit set/reset register: masked update words are staged in a
// small FIFO and each apply strobe pops the head into the persistent word q.
module multibit_set_reset_queue #(
    parameter int BITS   = 38,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic clock,
    input  logic reset,
    multibit_set_reset_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        M_LOAD   = 2'd0,
        M_SET    = 2'd1,
        M_CLEAR  = 2'd2,
        M_TOGGLE = 2'd3
    } mode_e;

    typedef struct packed {
        logic [1:0]        mode;
        logic [BITS-1:0]   mask;
        logic [BITS-1:0]   value;
        logic [DATA_W-1:0] payload;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BITS-1:0]   q_q, q_d;
    logic [DATA_W-1:0] db_q, db_d;
    logic              applied_q, applied_d;
    logic              full_q, empty_q;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              is_full, is_empty, do_apply, do_push;
    entry_t            head, wr_entry;
    logic [BITS-1:0]   vk;

    assign is_full  = (cnt_q == CNT_W'(DEPTH));
    assign is_empty = (cnt_q == '0);
    // Clear wins over everything; a full FIFO still accepts a push when the
    // head leaves on the same edge.
    assign do_apply = bus.apply && !is_empty && !bus.clear;
    assign do_push  = bus.push && (!is_full || do_apply) && !bus.clear;
    assign head     = mem_q[rd_ptr_q];
    assign vk       = head.value & head.mask;
    assign wr_entry = '{mode: bus.mode, mask: bus.set_mask,
                        value: bus.set_data, payload: bus.data};

    // Entry storage: written on accepted push only, no reset needed.
    always_ff @(posedge clock) begin
        if (do_push)
            mem_q[wr_ptr_q] <= wr_entry;
    end

    // Next-state for pointers, occupancy, output word and sticky flags.
    always_comb begin
        q_d       = q_q;
        db_d      = db_q;
        applied_d = 1'b0;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        if (bus.clear) begin
            q_d      = '0;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (do_apply) begin
                case (mode_e'(head.mode))
                    M_LOAD:   q_d = (q_q & ~head.mask) | vk;
                    M_SET:    q_d = q_q | vk;
                    M_CLEAR:  q_d = q_q & ~vk;
                    M_TOGGLE: q_d = q_q ^ vk;
                    default:  q_d = q_q;
                endcase
                db_d      = head.payload;
                applied_d = 1'b1;
                rd_ptr_d  = rd_ptr_q + 1'b1;
            end
            if (do_push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_push && !do_apply)
                cnt_d = cnt_q + CNT_W'(1);
            else if (do_apply && !do_push)
                cnt_d = cnt_q - CNT_W'(1);
            if (bus.push && !do_push)
                ovf_d = 1'b1;
            if (bus.apply && is_empty)
                unf_d = 1'b1;
        end
    end

    // State registers; full/empty are registered from next occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q       <= '0;
            db_q      <= '0;
            applied_q <= 1'b0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            q_q       <= q_d;
            db_q      <= db_d;
            applied_q <= applied_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            full_q    <= (cnt_d == CNT_W'(DEPTH));
            empty_q   <= (cnt_d == '0);
        end
    end

    assign bus.q           = q_q;
    assign bus.data_buffer = db_q;
    assign bus.applied     = applied_q;
    assign bus.count       = cnt_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule
